tm1638_bcd_display_ctrl: RTL and testbench

Sequences the TM1638 LED&KEY board from the 3-digit BCD counter value (12-bit packed {hundreds,tens,ones}) plus 8 discrete LEDs. On an update request it snapshots the inputs and encodes the digits to 7-segment. It then emits the three TM1638 command frames over STB/CLK/DIO: data-write, address+16 data bytes, display-control. It sits between the BCD counter and the board pins and is the only master of the TM1638 bus.

---
 rtl/tm1638_bcd_display_ctrl_if.sv | 11 +
 rtl/tm1638_bcd_display_ctrl.sv | 223 ++++++++++++++++++++++
 tb/tb_tm1638_bcd_display_ctrl.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/tm1638_bcd_display_ctrl_if.sv
// Request-side bundle between the BCD counter and the TM1638 display sequencer.
interface tm1638_bcd_display_ctrl_if;
    logic [11:0] bcd_in;
    logic [7:0]  leds;
    logic        update;
    logic        busy;
    logic        done;

    modport master (output bcd_in, leds, update, input busy, done);
    modport slave  (input bcd_in, leds, update, output busy, done);
endinterface

// File: rtl/tm1638_bcd_display_ctrl.sv
// TM1638 LED&KEY sequencer: snapshots a 3-digit BCD value plus 8 LEDs and sends
// the data-write, address+data and display-control frames. Optional: LEAD_ZERO_BLANK_EN.
module tm1638_bcd_display_ctrl #(
    parameter int unsigned CLK_DIV    = 4,
    parameter int unsigned BRIGHTNESS = 7
) (
    input  logic                            clk,
    input  logic                            rst,
    tm1638_bcd_display_ctrl_if.slave        req,
    output logic                            tm_stb,
    output logic                            tm_clk,
    output logic                            tm_dio
);
    localparam int unsigned DIV_W  = 8;
    localparam int unsigned BIT_W  = 3;
    localparam int unsigned BYTE_W = 5;
    localparam int unsigned FRM_W  = 2;

    localparam logic [DIV_W-1:0]  DIV_LOAD = DIV_W'(CLK_DIV - 1);
    localparam logic [7:0]        CMD_DATA = 8'h40;
    localparam logic [7:0]        CMD_ADDR = 8'hC0;
    localparam logic [7:0]        CMD_DISP = 8'h88 | 8'(BRIGHTNESS & 32'd7);
    localparam logic [BYTE_W-1:0] F2_LAST  = BYTE_W'(16);

    typedef enum logic [2:0] {
        S_IDLE, S_STB_SETUP, S_SHIFT_LO, S_SHIFT_HI, S_STB_HOLD, S_GAP, S_DONE
    } state_t;

    state_t              r_state;
    logic [DIV_W-1:0]    r_div;
    logic [BIT_W-1:0]    r_bit;
    logic [BYTE_W-1:0]   r_byte;
    logic [FRM_W-1:0]    r_frame;
    logic                r_gap_half;
    logic                r_pending;
    logic [11:0]         r_bcd;
    logic [7:0]          r_leds;
    logic                r_busy, r_done, r_stb, r_clk, r_dio;

    logic                w_blank_h, w_blank_t;
    logic [7:0]          w_seg_h, w_seg_t, w_seg_o;
    logic                w_div_zero, w_last_bit, w_last_byte;
    logic [BYTE_W-1:0]   w_next_byte;
    logic [BIT_W-1:0]    w_next_bit_idx;
    logic [7:0]          w_cur_val, w_next_val;

    function automatic logic [7:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 8'h3F;
            4'd1:    seg7 = 8'h06;
            4'd2:    seg7 = 8'h5B;
            4'd3:    seg7 = 8'h4F;
            4'd4:    seg7 = 8'h66;
            4'd5:    seg7 = 8'h6D;
            4'd6:    seg7 = 8'h7D;
            4'd7:    seg7 = 8'h07;
            4'd8:    seg7 = 8'h7F;
            4'd9:    seg7 = 8'h6F;
            default: seg7 = 8'h40;
        endcase
    endfunction

    // Byte idx of frame: F2 index 0 is the address command, then display RAM 00..0F.
    function automatic logic [7:0] frame_byte(input logic [FRM_W-1:0]  frame,
                                              input logic [BYTE_W-1:0] idx,
                                              input logic [7:0]        seg_h,
                                              input logic [7:0]        seg_t,
                                              input logic [7:0]        seg_o,
                                              input logic [7:0]        led_v);
        logic [3:0] addr;
        addr = 4'(idx - BYTE_W'(1));
        frame_byte = 8'h00;
        if (frame == FRM_W'(0)) begin
            frame_byte = CMD_DATA;
        end else if (frame == FRM_W'(1)) begin
            if (idx == '0) begin
                frame_byte = CMD_ADDR;
            end else if (addr[0]) begin
                frame_byte = {7'b0, led_v[addr[3:1]]};
            end else begin
                case (addr[3:1])
                    3'd5:    frame_byte = seg_h;
                    3'd6:    frame_byte = seg_t;
                    3'd7:    frame_byte = seg_o;
                    default: frame_byte = 8'h00;
                endcase
            end
        end else begin
            frame_byte = CMD_DISP;
        end
    endfunction

`ifdef LEAD_ZERO_BLANK_EN
    assign w_blank_h = (r_bcd[11:8] == 4'd0);
    assign w_blank_t = w_blank_h && (r_bcd[7:4] == 4'd0);
`else
    assign w_blank_h = 1'b0;
    assign w_blank_t = 1'b0;
`endif

    assign w_seg_h = w_blank_h ? 8'h00 : seg7(r_bcd[11:8]);
    assign w_seg_t = w_blank_t ? 8'h00 : seg7(r_bcd[7:4]);
    assign w_seg_o = seg7(r_bcd[3:0]);

    assign w_div_zero     = (r_div == '0);
    assign w_last_bit     = (r_bit == BIT_W'(7));
    assign w_last_byte    = (r_frame == FRM_W'(1)) ? (r_byte == F2_LAST) : (r_byte == '0);
    assign w_next_byte    = w_last_bit ? r_byte + BYTE_W'(1) : r_byte;
    assign w_next_bit_idx = r_bit + BIT_W'(1);
    assign w_cur_val      = frame_byte(r_frame, r_byte, w_seg_h, w_seg_t, w_seg_o, r_leds);
    assign w_next_val     = frame_byte(r_frame, w_next_byte, w_seg_h, w_seg_t, w_seg_o, r_leds);

    // Frame sequencer; every state dwells a whole number of divider periods.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_div      <= '0;
            r_bit      <= '0;
            r_byte     <= '0;
            r_frame    <= '0;
            r_gap_half <= 1'b0;
            r_pending  <= 1'b0;
            r_bcd      <= '0;
            r_leds     <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_stb      <= 1'b1;
            r_clk      <= 1'b1;
            r_dio      <= 1'b1;
        end else begin
            r_done <= 1'b0;
            if (!w_div_zero) r_div <= r_div - DIV_W'(1);
            if (req.update && (r_state != S_IDLE)) r_pending <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (req.update || r_pending) begin
                        r_bcd     <= req.bcd_in;
                        r_leds    <= req.leds;
                        r_pending <= 1'b0;
                        r_busy    <= 1'b1;
                        r_stb     <= 1'b0;
                        r_frame   <= '0;
                        r_bit     <= '0;
                        r_byte    <= '0;
                        r_div     <= DIV_LOAD;
                        r_state   <= S_STB_SETUP;
                    end
                end
                S_STB_SETUP: begin
                    if (w_div_zero) begin
                        r_clk   <= 1'b0;
                        r_dio   <= w_cur_val[r_bit];
                        r_div   <= DIV_LOAD;
                        r_state <= S_SHIFT_LO;
                    end
                end
                S_SHIFT_LO: begin
                    if (w_div_zero) begin
                        r_clk   <= 1'b1;
                        r_div   <= DIV_LOAD;
                        r_state <= S_SHIFT_HI;
                    end
                end
                S_SHIFT_HI: begin
                    if (w_div_zero) begin
                        r_div <= DIV_LOAD;
                        if (w_last_bit && w_last_byte) begin
                            r_state <= S_STB_HOLD;
                        end else begin
                            r_bit   <= w_next_bit_idx;
                            r_byte  <= w_next_byte;
                            r_clk   <= 1'b0;
                            r_dio   <= w_next_val[w_next_bit_idx];
                            r_state <= S_SHIFT_LO;
                        end
                    end
                end
                S_STB_HOLD: begin
                    if (w_div_zero) begin
                        r_stb      <= 1'b1;
                        r_dio      <= 1'b1;
                        r_gap_half <= 1'b0;
                        r_div      <= DIV_LOAD;
                        r_state    <= S_GAP;
                    end
                end
                S_GAP: begin
                    // Gap is two divider periods so the 8-bit divider covers CLK_DIV up to 255.
                    if (w_div_zero) begin
                        if (!r_gap_half) begin
                            r_gap_half <= 1'b1;
                            r_div      <= DIV_LOAD;
                        end else if (r_frame == FRM_W'(2)) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_frame <= r_frame + FRM_W'(1);
                            r_stb   <= 1'b0;
                            r_bit   <= '0;
                            r_byte  <= '0;
                            r_div   <= DIV_LOAD;
                            r_state <= S_STB_SETUP;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign tm_stb   = r_stb;
    assign tm_clk   = r_clk;
    assign tm_dio   = r_dio;
    assign req.busy = r_busy;
    assign req.done = r_done;

endmodule

// File: tb/tb_tm1638_bcd_display_ctrl.sv
// Scoreboard bench: stimulus pushes expected TM1638 frames, a pin-level decoder pops and compares.
module tb_tm1638_bcd_display_ctrl;
    localparam int unsigned CLK_DIV = 2;
    localparam int unsigned BRIGHT  = 7;
    localparam int unsigned LATENCY = 316 * CLK_DIV;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tm_stb, tm_clk, tm_dio;

    tm1638_bcd_display_ctrl_if bus();

    tm1638_bcd_display_ctrl #(.CLK_DIV(CLK_DIV), .BRIGHTNESS(BRIGHT)) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (bus),
        .tm_stb (tm_stb),
        .tm_clk (tm_clk),
        .tm_dio (tm_dio)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Reference model: segment table and TM1638 display RAM layout.
    logic [7:0] seg_lut [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                 8'h7F, 8'h6F, 8'h40, 8'h40, 8'h40, 8'h40, 8'h40, 8'h40};
    logic [7:0] exp_bytes[$];
    int         exp_len[$];
    int         exp_done = 0;

    task automatic push_expected(input logic [11:0] bcd, input logic [7:0] ld);
        int h, t, o;
        logic [7:0] grid [8];
        h = int'(bcd) / 256;
        t = (int'(bcd) / 16) % 16;
        o = int'(bcd) % 16;
        for (int g = 0; g < 8; g++) grid[g] = 8'h00;
        grid[5] = seg_lut[h];
        grid[6] = seg_lut[t];
        grid[7] = seg_lut[o];
`ifdef LEAD_ZERO_BLANK_EN
        if (h == 0) grid[5] = 8'h00;
        if (h == 0 && t == 0) grid[6] = 8'h00;
`endif
        exp_len.push_back(1);
        exp_bytes.push_back(8'h40);
        exp_len.push_back(17);
        exp_bytes.push_back(8'hC0);
        for (int a = 0; a < 16; a++)
            exp_bytes.push_back((a % 2 == 1) ? {7'b0, ld[a / 2]} : grid[a / 2]);
        exp_len.push_back(1);
        exp_bytes.push_back(8'h88 + 8'(BRIGHT));
        exp_done++;
    endtask

    // Monitor: decode frames from the pins on the falling system clock edge.
    int         cyc        = 0;
    int         busy_start = 0;
    int         busy_rises = 0;
    int         clk_edges  = 0;
    int         nbits      = 0;
    bit         aborting   = 1'b0;
    logic       prev_clk   = 1'b1;
    logic       prev_stb   = 1'b1;
    logic       prev_busy  = 1'b0;
    logic [7:0] shreg      = 8'h00;
    logic [7:0] rx[$];

    task automatic frame_end();
        int n;
        logic [7:0] e, g;
        check("frame_bit_align", 32'(nbits), 0);
        if (exp_len.size() == 0) begin
            check("frame_expected", 32'(rx.size()), 0);
        end else begin
            n = exp_len.pop_front();
            check("frame_len", 32'(rx.size()), 32'(n));
            for (int i = 0; i < n; i++) begin
                e = (exp_bytes.size() > 0) ? exp_bytes.pop_front() : 8'h00;
                g = (i < rx.size()) ? rx[i] : 8'hxx;
                check($sformatf("frame_byte%0d", i), {24'h0, g}, {24'h0, e});
            end
        end
        rx.delete();
        nbits = 0;
    endtask

    always @(negedge clk) begin
        cyc++;
        if (tm_clk !== prev_clk) clk_edges++;
        if (aborting) begin
            nbits = 0;
            rx.delete();
        end else begin
            if (!prev_clk && tm_clk && !tm_stb) begin
                shreg = {tm_dio, shreg[7:1]};
                nbits++;
                if (nbits == 8) begin
                    rx.push_back(shreg);
                    nbits = 0;
                end
            end
            if (!prev_stb && tm_stb) frame_end();
        end
        if (bus.busy === 1'b1 && prev_busy !== 1'b1) begin
            busy_start = cyc;
            busy_rises++;
        end
        if (bus.done === 1'b1) begin
            check("done_expected", 32'(exp_done > 0), 1);
            check("latency", 32'(cyc - busy_start), 32'(LATENCY));
            check("busy_low_at_done", 32'(bus.busy), 0);
            if (exp_done > 0) exp_done--;
        end
        prev_clk  = tm_clk;
        prev_stb  = tm_stb;
        prev_busy = bus.busy;
    end

    task automatic issue(input logic [11:0] b, input logic [7:0] l);
        bus.bcd_in = b;
        bus.leds   = l;
        bus.update = 1'b1;
        push_expected(b, l);
        @(negedge clk);
        bus.update = 1'b0;
    endtask

    // Wait for done; optionally disturb inputs, add requests, and run any follow-up refresh.
    task automatic wait_done(input bit pend_in, input bit scramble, input bit allow_req,
                             input bit req_in_done);
        bit pend, more;
        int n;
        pend = pend_in;
        more = 1'b1;
        while (more) begin
            n = 0;
            while (bus.done !== 1'b1 && n < int'(LATENCY) + 50) begin
                if (scramble && $urandom_range(0, 19) == 0) begin
                    bus.bcd_in = 12'($urandom);
                    bus.leds   = 8'($urandom);
                end
                bus.update = allow_req && ($urandom_range(0, 99) == 0) && (bus.busy === 1'b1);
                if (bus.update) pend = 1'b1;
                @(negedge clk);
                n++;
            end
            bus.update = 1'b0;
            check("done_seen", 32'(bus.done), 1);
            if (req_in_done) begin
                bus.update = 1'b1;
                pend = 1'b1;
            end
            more = pend;
            if (pend) push_expected(bus.bcd_in, bus.leds);
            @(negedge clk);
            bus.update  = 1'b0;
            pend        = 1'b0;
            scramble    = 1'b0;
            allow_req   = 1'b0;
            req_in_done = 1'b0;
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int e0, r0;
        bus.bcd_in = '0;
        bus.leds   = '0;
        bus.update = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_stb", 32'(tm_stb), 1);
        check("rst_clk", 32'(tm_clk), 1);
        check("rst_dio", 32'(tm_dio), 1);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_done", 32'(bus.done), 0);
        e0 = clk_edges;
        repeat (1000) @(negedge clk);
        check("idle_clk_edges", 32'(clk_edges - e0), 0);
        check("idle_busy_rises", 32'(busy_rises), 0);

        issue(12'h123, 8'h01);
        wait_done(1'b0, 1'b0, 1'b0, 1'b0);
        issue(12'h1A5, 8'h80);
        wait_done(1'b0, 1'b0, 1'b0, 1'b0);

        // Requests during a transfer coalesce into one follow-up.
        r0 = busy_rises;
        issue(12'h111, 8'h00);
        repeat (49) @(negedge clk);
        bus.bcd_in = 12'h456;
        bus.update = 1'b1;
        @(negedge clk);
        bus.update = 1'b0;
        repeat (249) @(negedge clk);
        bus.update = 1'b1;
        @(negedge clk);
        bus.update = 1'b0;
        wait_done(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (700) @(negedge clk);
        check("coalesce_transfers", 32'(busy_rises - r0), 2);

        // Reset mid-transfer with a pending request.
        issue(12'h789, 8'h5A);
        repeat (49) @(negedge clk);
        bus.update = 1'b1;
        @(negedge clk);
        bus.update = 1'b0;
        repeat (50) @(negedge clk);
        rst      = 1'b1;
        aborting = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_stb", 32'(tm_stb), 1);
        check("abort_clk", 32'(tm_clk), 1);
        check("abort_dio", 32'(tm_dio), 1);
        check("abort_busy", 32'(bus.busy), 0);
        exp_bytes.delete();
        exp_len.delete();
        exp_done = 0;
        r0 = busy_rises;
        repeat (3) @(negedge clk);
        aborting = 1'b0;
        repeat (1000) @(negedge clk);
        check("abort_no_pending", 32'(busy_rises - r0), 0);
        issue(12'h246, 8'hC3);
        wait_done(1'b0, 1'b0, 1'b0, 1'b0);

        issue(12'h007, 8'hFF);
        wait_done(1'b0, 1'b0, 1'b0, 1'b0);
        issue(12'h000, 8'h00);
        wait_done(1'b0, 1'b0, 1'b0, 1'b0);
        issue(12'h0F0, 8'h3C);
        wait_done(1'b0, 1'b0, 1'b0, 1'b0);

        for (int it = 0; it < 8; it++) begin
            issue(12'($urandom), 8'($urandom));
            wait_done(1'b0, 1'b1, 1'b1, (it % 3) == 0);
        end

        repeat (20) @(negedge clk);
        check("exp_done_left", 32'(exp_done), 0);
        check("frames_left", 32'(exp_len.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #4000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
